// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU operation
// encodings, base opcodes and the layout of the 8-bit control bundle.
package id_ex_reg_pkg;

  // ALUop encodings produced by the decoder
  localparam logic [1:0] ALUOP_LDST   = 2'b00;  // load/store address add
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // register-register ALU
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;  // register-immediate ALU

  // Base opcodes
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  // Control bundle width and bit order {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUop}
  localparam int unsigned CTRL_W = 8;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  // Bubble / reset value of the control bundle: nothing writes, nothing touches memory
  localparam ctrl_t CTRL_NOP = 8'b0000_0000;

endpackage

// File: rtl/id_ex_reg_field.sv
// One pipeline register field of parameterised width with separate reset
// and flush values and a load enable. Priority: reset > flush > hold > load.
module pipe_field #(
  parameter int unsigned   W         = 1,
  parameter logic [W-1:0]  RST_VAL   = {W{1'b0}},
  parameter logic [W-1:0]  FLUSH_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Field register: reset wins over flush, flush wins over stall, else load
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (flush) begin
      q <= FLUSH_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Every _EX output is a flop; the only logic
// beyond the flops is the two hazard helper gates at the bottom.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic        flush,
  input  logic        ALUSrc_ID,
  input  logic        MemtoReg_ID,
  input  logic        RegWrite_ID,
  input  logic        MemRead_ID,
  input  logic        MemWrite_ID,
  input  logic        Branch_ID,
  input  logic [1:0]  ALUop_ID,
  input  logic        valid_ID,
  input  logic [31:0] PC_ID,
  input  logic [31:0] REG_DATA1_ID,
  input  logic [31:0] REG_DATA2_ID,
  input  logic [31:0] IMM_ID,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  input  logic [4:0]  RD_ID,
  input  logic [2:0]  FUNCT3_ID,
  input  logic [6:0]  FUNCT7_ID,
  output logic        ALUSrc_EX,
  output logic        MemtoReg_EX,
  output logic        RegWrite_EX,
  output logic        MemRead_EX,
  output logic        MemWrite_EX,
  output logic        Branch_EX,
  output logic [1:0]  ALUop_EX,
  output logic        valid_EX,
  output logic [31:0] PC_EX,
  output logic [31:0] REG_DATA1_EX,
  output logic [31:0] REG_DATA2_EX,
  output logic [31:0] IMM_EX,
  output logic [4:0]  RS1_EX,
  output logic [4:0]  RS2_EX,
  output logic [4:0]  RD_EX,
  output logic [2:0]  FUNCT3_EX,
  output logic [6:0]  FUNCT7_EX,
  output logic        ex_writes_rd,
  output logic        ex_is_load
);

  ctrl_t ctrl_id_s;
  ctrl_t ctrl_ex_s;

  assign ctrl_id_s = {ALUSrc_ID, MemtoReg_ID, RegWrite_ID, MemRead_ID,
                      MemWrite_ID, Branch_ID, ALUop_ID};

  pipe_field #(.W(CTRL_W), .RST_VAL(CTRL_NOP), .FLUSH_VAL(CTRL_NOP)) u_ctrl (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(ctrl_id_s), .q(ctrl_ex_s));

  assign ALUSrc_EX   = ctrl_ex_s.alusrc;
  assign MemtoReg_EX = ctrl_ex_s.memtoreg;
  assign RegWrite_EX = ctrl_ex_s.regwrite;
  assign MemRead_EX  = ctrl_ex_s.memread;
  assign MemWrite_EX = ctrl_ex_s.memwrite;
  assign Branch_EX   = ctrl_ex_s.branch;
  assign ALUop_EX    = ctrl_ex_s.aluop;

  pipe_field #(.W(1), .RST_VAL(1'b0), .FLUSH_VAL(1'b0)) u_valid (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(valid_ID), .q(valid_EX));

  // PC returns to RESET_PC on both reset and bubble so a bubble carries a known PC
  pipe_field #(.W(32), .RST_VAL(RESET_PC), .FLUSH_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(PC_ID), .q(PC_EX));

  pipe_field #(.W(32), .RST_VAL(32'h0000_0000), .FLUSH_VAL(32'h0000_0000)) u_rd1 (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(REG_DATA1_ID), .q(REG_DATA1_EX));

  pipe_field #(.W(32), .RST_VAL(32'h0000_0000), .FLUSH_VAL(32'h0000_0000)) u_rd2 (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(REG_DATA2_ID), .q(REG_DATA2_EX));

  pipe_field #(.W(32), .RST_VAL(32'h0000_0000), .FLUSH_VAL(32'h0000_0000)) u_imm (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(IMM_ID), .q(IMM_EX));

  // Register indices clear to x0 so forwarding never matches a bubble
  pipe_field #(.W(5), .RST_VAL(5'd0), .FLUSH_VAL(5'd0)) u_rs1 (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(RS1_ID), .q(RS1_EX));

  pipe_field #(.W(5), .RST_VAL(5'd0), .FLUSH_VAL(5'd0)) u_rs2 (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(RS2_ID), .q(RS2_EX));

  pipe_field #(.W(5), .RST_VAL(5'd0), .FLUSH_VAL(5'd0)) u_rd (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(RD_ID), .q(RD_EX));

  pipe_field #(.W(3), .RST_VAL(3'd0), .FLUSH_VAL(3'd0)) u_f3 (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(FUNCT3_ID), .q(FUNCT3_EX));

  pipe_field #(.W(7), .RST_VAL(7'd0), .FLUSH_VAL(7'd0)) u_f7 (
    .clk(clk), .reset(reset), .flush(flush), .en(write), .d(FUNCT7_ID), .q(FUNCT7_EX));

  // Hazard helpers, decoded from registered state only
  assign ex_writes_rd = valid_EX & RegWrite_EX & (RD_EX != 5'd0);
  assign ex_is_load   = valid_EX & MemRead_EX;

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 SHALL have ports: write input 1 (0 = stall, hold); flush input 1 (1 = insert bubble).
REQ-003 SHALL have control inputs, each 1 bit: ALUSrc_ID, MemtoReg_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, Branch_ID; ALUop_ID input 2; valid_ID input 1.
REQ-004 SHALL have data inputs: PC_ID 32; REG_DATA1_ID 32; REG_DATA2_ID 32; IMM_ID 32; RS1_ID 5; RS2_ID 5; RD_ID 5; FUNCT3_ID 3; FUNCT7_ID 7.
REQ-005 SHALL have registered outputs mirroring each REQ-003/REQ-004 input with suffix _EX, same widths.
REQ-006 SHALL have parameter RESET_PC, default 32'h0, the PC_EX value loaded on reset and flush.

Function
REQ-007 SHALL update all _EX outputs only on rising clk; no combinational input-to-output path.
REQ-008 SHALL apply per-edge priority: reset > flush > (write==0 hold) > load.
REQ-009 On load (write=1, flush=0, reset=0), SHALL capture every _ID input into its _EX output; latency exactly 1 cycle.
REQ-010 On hold (write=0, flush=0), SHALL keep every _EX output unchanged, including valid_EX.
REQ-011 On flush, SHALL clear ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUop, valid to 0, and clear RD_EX, RS1_EX, RS2_EX to 0 so forwarding logic never matches a bubble.
REQ-012 On flush, SHALL also clear data fields (REG_DATA1/2, IMM, FUNCT3/7) to 0 and load PC_EX with RESET_PC.
REQ-013 Flush with write=0 in the same cycle SHALL still produce a bubble (flush wins over stall).
REQ-014 SHALL treat an all-zero control bundle from upstream (hazard-unit or ISA nop) as ordinary data: it is captured unchanged, and valid_EX follows valid_ID.
REQ-015 SHALL expose ex_writes_rd output 1, combinational from registered state: valid_EX & RegWrite_EX & (RD_EX != 0); used by hazard/forwarding.
REQ-016 SHALL expose ex_is_load output 1, combinational: valid_EX & MemRead_EX; used by load-use hazard detection.
REQ-017 SHALL hold state indefinitely across consecutive stall cycles; the first write=1 edge after a stall loads the then-current _ID values.

Reset
REQ-018 Synchronous reset SHALL force all control outputs, valid_EX, RS1/RS2/RD, data fields and FUNCT fields to 0, and PC_EX to RESET_PC, on the first rising edge with reset=1.
REQ-019 Reset asserted mid-stall or mid-flush SHALL take priority; after deassertion the next edge behaves per REQ-008.
REQ-020 Outputs between power-up and first reset edge are unspecified; the bench SHALL not check them.

Structure
REQ-021 Shared include file SHALL hold: ALUop encodings (00 load/store add, 01 branch compare, 10 R-type, 11 I-type ALU), opcode constants (LW 0000011, SW 0100011, R 0110011, I 0010011, BR 1100011), and the 8-bit control-bundle bit order {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUop}.
REQ-022 SHALL instantiate one sub-module pipe_field, a parameterised-width register with reset value, flush value and enable, once for the control bundle and once per data field.
REQ-023 SHALL contain no other logic than REQ-015/REQ-016 gates.

Verification
REQ-024 Load: reset 2 cycles, then write=1, lw bundle 8'b11110000, RD_ID=5, PC_ID=32'h10 -> next edge RD_EX=5, PC_EX=32'h10, ex_is_load=1, ex_writes_rd=1.
REQ-025 Stall: after REQ-024, write=0 for 3 cycles with R-type bundle 8'b00100010 at inputs -> outputs stay lw values all 3 cycles; write=1 -> R-type loaded next edge.
REQ-026 Flush vs stall: write=0, flush=1 with valid lw in EX -> next edge all control=0, RD_EX=0, valid_EX=0, PC_EX=RESET_PC, ex_is_load=0.
REQ-027 Reset priority: reset=1, flush=1, write=1, sw bundle 8'b10001000 -> all outputs reset values; reset=0 next cycle with same inputs -> flush result.
REQ-028 x0 write: R-type bundle, RD_ID=0, valid_ID=1 -> RegWrite_EX=1, ex_writes_rd=0.
REQ-029 Nop passthrough: control bundle 8'b00000000, valid_ID=1, RD_ID=7 -> RD_EX=7, valid_EX=1, ex_writes_rd=0, ex_is_load=0.
